// File: rtl/hmc_rx_flit_packer.sv
// hmc_rx_flit_packer: store-and-forward packer of HMC response flits onto the PHY RX beat bus
// Buffers a whole packet, then emits it FPW flits per beat starting at slot 0, zero padding
// the tail of the last beat; all-zero NULL words fill the bus between packets.
// Ports: clk/res_n (async active-low reset); flit_in/flit_valid/flit_ready flit input handshake
// (LNG in flit_in[10:7] of the header); phy_data_rx_phy2link/beat_valid registered beat output;
// err_lng one-cycle pulse on a dropped illegal header; pkt_count/flit_count emitted totals,
// live only when HMC_RX_PACKER_STATS_EN is defined, constant 0 otherwise.
module hmc_rx_flit_packer #(
  parameter int DWIDTH    = 512,
  parameter int FPW       = 4,
  parameter int FLIT_SIZE = 128,
  parameter int MAX_FLITS = 9
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic [FLIT_SIZE-1:0] flit_in,
  input  logic                 flit_valid,
  output logic                 flit_ready,
  output logic [DWIDTH-1:0]    phy_data_rx_phy2link,
  output logic                 beat_valid,
  output logic                 err_lng,
  output logic [31:0]          pkt_count,
  output logic [31:0]          flit_count
);
  localparam int BW = $clog2(MAX_FLITS);
  typedef enum logic {COLLECT, EMIT} state_t;
  state_t state_q, state_d;
  logic [3:0] lng_q, lng_d, idx_q, idx_d, hdr_lng;
  logic [4:0] b_q, b_d, nb;
  logic [FLIT_SIZE-1:0] buf_q [MAX_FLITS];
  logic [DWIDTH-1:0] data_d, beat;
  logic bv_d, err_d, wr_en, last_beat;
  assign hdr_lng    = flit_in[10:7];
  assign nb         = (5'(lng_q) + 5'(FPW - 1)) / 5'(FPW);
  assign last_beat  = (state_q == EMIT) && (b_q == nb - 5'd1);
  assign flit_ready = (state_q == COLLECT);
  // Slots past LNG are masked to zero; stale buffer entries never leak onto the bus.
  for (genvar s = 0; s < FPW; s++) begin : g_slot
    logic [7:0] k;
    assign k = 8'(b_q) * 8'(FPW) + 8'(s);
    assign beat[s*FLIT_SIZE +: FLIT_SIZE] = (k < 8'(lng_q)) ? buf_q[k[BW-1:0]] : '0;
  end
  always_comb begin
    state_d = state_q;
    lng_d   = lng_q;
    idx_d   = idx_q;
    b_d     = b_q;
    data_d  = '0;
    bv_d    = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    if (state_q == COLLECT) begin
      if (flit_valid) begin
        if (idx_q == 4'd0) begin
          if (hdr_lng == 4'd0 || hdr_lng > 4'(MAX_FLITS)) begin
            err_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            lng_d   = hdr_lng;
            idx_d   = 4'd1;
            b_d     = 5'd0;
            state_d = (hdr_lng == 4'd1) ? EMIT : COLLECT;
          end
        end else begin
          wr_en   = 1'b1;
          idx_d   = idx_q + 4'd1;
          b_d     = 5'd0;
          state_d = (idx_q + 4'd1 == lng_q) ? EMIT : COLLECT;
        end
      end
    end else begin
      data_d  = beat;
      bv_d    = 1'b1;
      b_d     = b_q + 5'd1;
      state_d = last_beat ? COLLECT : EMIT;
      idx_d   = last_beat ? 4'd0 : idx_q;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[idx_q[BW-1:0]] <= flit_in;
  end
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q              <= COLLECT;
      lng_q                <= '0;
      idx_q                <= '0;
      b_q                  <= '0;
      phy_data_rx_phy2link <= '0;
      beat_valid           <= 1'b0;
      err_lng              <= 1'b0;
    end else begin
      state_q              <= state_d;
      lng_q                <= lng_d;
      idx_q                <= idx_d;
      b_q                  <= b_d;
      phy_data_rx_phy2link <= data_d;
      beat_valid           <= bv_d;
      err_lng              <= err_d;
    end
  end
`ifdef HMC_RX_PACKER_STATS_EN
  logic [31:0] pkt_q, flit_q;
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      pkt_q  <= '0;
      flit_q <= '0;
    end else if (last_beat) begin
      pkt_q  <= pkt_q + 32'd1;
      flit_q <= flit_q + 32'(lng_q);
    end
  end
  assign pkt_count  = pkt_q;
  assign flit_count = flit_q;
`else
  assign pkt_count  = '0;
  assign flit_count = '0;
`endif
endmodule

// File: tb/tb_hmc_rx_flit_packer.sv
// tb_hmc_rx_flit_packer: scoreboard bench for hmc_rx_flit_packer with cycle-stamped expected beats
module tb_hmc_rx_flit_packer;
  localparam int FPW  = 4;
  localparam int FS   = 128;
  localparam int DW   = 512;
  localparam int MAXF = 9;
`ifdef HMC_RX_PACKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0;
  logic res_n;
  logic [FS-1:0] flit_in;
  logic flit_valid;
  logic flit_ready;
  logic [DW-1:0] phy_data_rx_phy2link;
  logic beat_valid, err_lng;
  logic [31:0] pkt_count, flit_count;
  hmc_rx_flit_packer dut (
    .clk(clk), .res_n(res_n), .flit_in(flit_in), .flit_valid(flit_valid),
    .flit_ready(flit_ready), .phy_data_rx_phy2link(phy_data_rx_phy2link),
    .beat_valid(beat_valid), .err_lng(err_lng), .pkt_count(pkt_count), .flit_count(flit_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    int cyc;
    logic [DW-1:0] data;
    bit last;
    int lng;
  } beat_t;
  beat_t exp_q[$];
  int cyc = 0;
  int err_cyc = -1;
  int m_pkt = 0, m_flit = 0;
  int errors = 0, checks = 0;
  logic [DW-1:0] ed;
  logic ev;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask
  // Model: every completed packet schedules its beats on consecutive cycles after acceptance;
  // any cycle without a scheduled beat must show a NULL word.
  always @(negedge clk) begin
    ed = '0;
    ev = 1'b0;
    if (res_n && exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      ed = exp_q[0].data;
      ev = 1'b1;
      if (exp_q[0].last) begin
        m_pkt++;
        m_flit += exp_q[0].lng;
      end
      void'(exp_q.pop_front());
    end
    chk("data", phy_data_rx_phy2link, ed);
    chk("beat_valid", DW'(beat_valid), DW'(ev));
    chk("flit_ready", DW'(flit_ready), DW'(exp_q.size() == 0));
    chk("err_lng", DW'(err_lng), DW'(res_n && err_cyc == cyc));
    chk("pkt_count", DW'(pkt_count), DW'(STATS ? m_pkt : 0));
    chk("flit_count", DW'(flit_count), DW'(STATS ? m_flit : 0));
  end
  task automatic idle(input int n);
    flit_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  task automatic present(input logic [FS-1:0] f, input int stall, output int e);
    int t;
    flit_valid = 1'b0;
    @(negedge clk);
    repeat (stall) @(negedge clk);
    flit_in = f;
    flit_valid = 1'b1;
    t = 0;
    while (flit_ready !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 64) begin
      errors++;
      $error("FAIL ready_timeout observed=0 expected=1 within 64 cycles");
    end
    @(posedge clk);
    #1;
    e = cyc;
    flit_valid = 1'b0;
  endtask
  task automatic send_pkt(input int lng, input int nsend, input int stall_max);
    logic [FS-1:0] fl[$];
    logic [FS-1:0] f;
    logic [DW-1:0] bt;
    int n, e, nb, k;
    bit legal;
    legal = (lng >= 1 && lng <= MAXF);
    n = legal ? lng : 1;
    for (int i = 0; i < n; i++) begin
      f = {$urandom, $urandom, $urandom, $urandom};
      if (i == 0) f[10:7] = 4'(lng);
      fl.push_back(f);
    end
    e = 0;
    for (int i = 0; i < n && i < nsend; i++) present(fl[i], $urandom_range(0, stall_max), e);
    if (nsend < n) return;
    if (!legal) begin
      err_cyc = e;
      return;
    end
    nb = (lng + FPW - 1) / FPW;
    for (int b = 0; b < nb; b++) begin
      bt = '0;
      for (int s = 0; s < FPW; s++) begin
        k = b * FPW + s;
        if (k < lng) bt[s*FS +: FS] = fl[k];
      end
      exp_q.push_back('{cyc: e + 1 + b, data: bt, last: (b == nb - 1), lng: lng});
    end
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2;
    res_n = 1'b0;
    flit_valid = 1'b0;
    exp_q.delete();
    m_pkt = 0;
    m_flit = 0;
    err_cyc = -1;
    repeat (2) @(posedge clk);
    #2;
    res_n = 1'b1;
  endtask
  initial begin
    int l;
    res_n = 1'b0;
    flit_valid = 1'b0;
    flit_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_data", phy_data_rx_phy2link, '0);
    chk("rst_ready", DW'(flit_ready), DW'(1));
    chk("rst_bv", DW'(beat_valid), DW'(0));
    @(posedge clk);
    #2;
    res_n = 1'b1;
    send_pkt(1, 1, 0);
    idle(3);
    send_pkt(5, 5, 0);
    idle(3);
    send_pkt(9, 9, 0);
    send_pkt(2, 2, 0);
    idle(4);
    send_pkt(0, 1, 0);
    send_pkt(1, 1, 0);
    idle(3);
    send_pkt(5, 3, 0);
    do_reset();
    send_pkt(1, 1, 0);
    idle(3);
    send_pkt(9, 9, 0);
    do_reset();
    idle(4);
    send_pkt(12, 1, 0);
    send_pkt(15, 1, 0);
    send_pkt(8, 8, 2);
    idle(3);
    for (int p = 0; p < 40; p++) begin
      l = ($urandom_range(0, 3) != 0) ? $urandom_range(1, MAXF) : $urandom_range(0, 15);
      send_pkt(l, 16, $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(6);
    do_reset();
    send_pkt(1, 1, 0);
    send_pkt(5, 5, 0);
    send_pkt(9, 9, 0);
    idle(6);
    chk("final_pkt", DW'(pkt_count), DW'(STATS ? 3 : 0));
    chk("final_flit", DW'(flit_count), DW'(STATS ? 15 : 0));
    chk("final_drain", DW'(exp_q.size()), DW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hmc_rx_flit_packer.md
# hmc_rx_flit_packer

Store-and-forward packer that takes HMC response packets one 128-bit flit per cycle and drives them onto the PHY-side RX data bus `phy_data_rx_phy2link`, FPW flits per beat. It sits directly upstream of the link controller's RX input, in the position the PHY normally occupies.

Each packet is buffered whole, then emitted as consecutive beats starting at slot 0. Unused slots in the last beat are zero. Between packets the bus carries all-zero NULL words.

## Interface

Parameters:

- `DWIDTH`, 512, PHY data width; must equal `FPW*FLIT_SIZE`.
- `FPW`, 4, flits per beat (1, 2, 4 or 8).
- `FLIT_SIZE`, 128, flit width in bits.
- `MAX_FLITS`, 9, buffer depth; largest legal LNG.

Ports:

- `clk`  in  1  single clock, rising edge.
- `res_n`  in  1  reset; asynchronous assert, active-low.
- `flit_in`  in  FLIT_SIZE  flit data; header LNG is `flit_in[10:7]` on the first flit.
- `flit_valid`  in  1  `flit_in` is valid.
- `flit_ready`  out  1  packer accepts a flit this cycle.
- `phy_data_rx_phy2link`  out  DWIDTH  registered beat; slot s occupies bits `[s*FLIT_SIZE +: FLIT_SIZE]`.
- `beat_valid`  out  1  high when the current bus word is a packet beat rather than NULL.
- `err_lng`  out  1  one-cycle pulse when an illegal LNG header is dropped.
- `pkt_count`  out  32  packets emitted (see Configuration).
- `flit_count`  out  32  flits emitted (see Configuration).

## Operation

- States: COLLECT and EMIT. Reset state is COLLECT.
- COLLECT:
  - `flit_ready` is 1; a flit is accepted when `flit_valid && flit_ready`.
  - The first accepted flit is the header. Its LNG is latched; flit index `idx` goes to 1 and the flit is stored in `buf[0]`.
  - Each following accepted flit is stored in `buf[idx]` and `idx` increments.
  - When `idx` reaches LNG, the state moves to EMIT with beat counter `b`=0 and `NB`=ceil(LNG/FPW).
  - An LNG=1 header goes to EMIT on the same edge that accepts it.
- Illegal LNG (0 or greater than MAX_FLITS):
  - The header flit is dropped and `err_lng` pulses for one cycle.
  - The state stays COLLECT and the next accepted flit is treated as a new header.
- EMIT:
  - `flit_ready` is 0.
  - On each edge the output register loads beat `b`: slot s carries `buf[b*FPW+s]` if `b*FPW+s < LNG`, otherwise zero. `beat_valid` is set to 1 and `b` increments.
  - When the edge loads beat `NB-1`, the state returns to COLLECT and `idx` clears.
- In COLLECT, every edge loads an all-zero word into `phy_data_rx_phy2link` and `beat_valid`=0.
  - A packet's beats are therefore always contiguous.
  - NULL words appear only between packets.
- Buffer contents are not cleared between packets; padding comes from the slot mask only.

## Timing

- Reset values: `phy_data_rx_phy2link`=0, `beat_valid`=0, `err_lng`=0, `flit_ready`=1, `pkt_count`=0, `flit_count`=0, state COLLECT, `idx`=0.
- Latency: last flit accepted at edge E gives beat 0 registered at E+1 and beat NB-1 registered at E+NB.
- Input gap: `flit_ready` is 0 from after E until after E+NB. The earliest next header is accepted at E+NB+1, so at least one NULL word follows each packet.
- `flit_valid` low mid-packet stalls collection with no timeout. The output stays NULL.
- `res_n` asserted mid-COLLECT or mid-EMIT:
  - All outputs are cleared immediately and any partial packet is discarded.
  - A packet interrupted in EMIT is never completed.
- `err_lng` is registered and asserts the cycle after the illegal header is accepted.

## Configuration

- Macro: `HMC_RX_PACKER_STATS_EN`.
- Defined:
  - `pkt_count` increments by 1 on each edge that loads beat `NB-1`.
  - `flit_count` increments by LNG on that same edge.
  - Both are 32-bit counters that wrap modulo 2^32.
  - Neither counter increments on dropped headers.
- Undefined: both ports are constant 0 and the counter registers are not synthesized.

## Test plan

All scenarios use default parameters unless stated.

- LNG=1 header `0x...A5` at edge E -> at E+1, slot 0 is `0x...A5`, slots 1-3 are 0, `beat_valid`=1. NULL at E+2. `flit_ready` is 1 again at E+2.
- LNG=5, flits F0..F4 -> beat 0 carries F0..F3; beat 1 carries F4 in slot 0 and zeros in slots 1-3; both beats on consecutive edges.
- LNG=9 back-to-back with LNG=2 and `flit_valid` held high -> 3 beats, then NULL, then 1 beat carrying F0,F1,0,0. `flit_ready` is low for exactly 3 cycles after the first packet.
- LNG=0 header, then a LNG=1 header -> `err_lng` pulses once. Only the LNG=1 packet appears on the bus.
- `res_n` low after 3 of 5 flits, then released -> bus stays 0. The next LNG=1 packet is emitted correctly.
- With `HMC_RX_PACKER_STATS_EN` defined: packets of LNG 1, 5 and 9 -> `pkt_count`=3, `flit_count`=15. With the macro undefined, both read 0.
